fig_04b_block_074_prefix_decode: RTL and testbench

// - Instruction-prefix and register-select decoder sitting directly upstream of the 16-entry register file / X-Y bus select stage.
// - Tracks SuperFX prefix state (Sreg, Dreg, B flag, ALT1/ALT2) across FROM/TO/WITH/ALTn opcodes.
// - For each non-prefix opcode, emits one registered decode word (xsel/ysel/zsel/fromset/zwen) and then clears prefix state.

---
 rtl/fig_04b_block_074_prefix_decode.sv | 116 +++++++++++
 tb/tb_fig_04b_block_074_prefix_decode.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fig_04b_block_074_prefix_decode.sv
// rtl/fig_04b_block_074_prefix_decode.sv - SuperFX prefix tracker and register-select decoder (option: FIG04B_BFLAG_MOVE_EN)
// Prefix ops update Sreg/Dreg/B/ALT state; every other op yields one registered decode word.
module fig_04b_block_074_prefix_decode #(
    parameter logic [3:0] RESET_REG = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] op,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic       dec_stall,
    output logic       dec_valid,
    output logic [3:0] xsel,
    output logic [3:0] ysel,
    output logic [3:0] zsel,
    output logic       fromset,
    output logic       zwen,
    output logic       flag_upd,
    output logic       alt1,
    output logic       alt2,
    output logic [7:0] dec_op
);

`ifdef FIG04B_BFLAG_MOVE_EN
    localparam bit FUSE_EN = 1'b1;
`else
    localparam bit FUSE_EN = 1'b0;
`endif

    logic [3:0] sreg, dreg;
    logic       bflag, alt1_st, alt2_st, src_set;

    logic       accept;
    logic [3:0] hi, lo;
    logic       is_with, is_move, is_moves, is_to, is_from, is_alt, is_prefix;
    logic [3:0] nx_xsel, nx_zsel;

    assign op_ready = !dec_valid || !dec_stall;
    assign accept   = op_valid && op_ready;
    assign hi       = op[7:4];
    assign lo       = op[3:0];

    // With B set, 0x1n/0xBn become MOVE/MOVES instead of TO/FROM prefixes.
    always_comb begin
        is_with   = (hi == 4'h2);
        is_move   = FUSE_EN && bflag && (hi == 4'h1);
        is_moves  = FUSE_EN && bflag && (hi == 4'hB);
        is_to     = (hi == 4'h1) && !is_move;
        is_from   = (hi == 4'hB) && !is_moves;
        is_alt    = (op == 8'h3D) || (op == 8'h3E) || (op == 8'h3F);
        is_prefix = is_with || is_to || is_from || is_alt;
        nx_xsel   = is_moves ? lo : sreg;
        nx_zsel   = is_move  ? lo : dreg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg      <= RESET_REG;
            dreg      <= RESET_REG;
            bflag     <= 1'b0;
            alt1_st   <= 1'b0;
            alt2_st   <= 1'b0;
            src_set   <= 1'b0;
            dec_valid <= 1'b0;
            xsel      <= 4'd0;
            ysel      <= 4'd0;
            zsel      <= 4'd0;
            fromset   <= 1'b0;
            zwen      <= 1'b0;
            flag_upd  <= 1'b0;
            alt1      <= 1'b0;
            alt2      <= 1'b0;
            dec_op    <= 8'h01;
        end else if (accept) begin
            if (is_prefix) begin
                dec_valid <= 1'b0;
                if (is_with) begin
                    sreg    <= lo;
                    dreg    <= lo;
                    bflag   <= 1'b1;
                    src_set <= 1'b1;
                end
                if (is_to)
                    dreg <= lo;
                if (is_from) begin
                    sreg    <= lo;
                    src_set <= 1'b1;
                end
                if (is_alt) begin
                    alt1_st <= alt1_st | op[0];
                    alt2_st <= alt2_st | op[1];
                end
            end else begin
                dec_valid <= 1'b1;
                dec_op    <= op;
                xsel      <= nx_xsel;
                ysel      <= lo;
                zsel      <= nx_zsel;
                fromset   <= src_set;
                zwen      <= is_move || is_moves;
                flag_upd  <= is_moves;
                alt1      <= alt1_st;
                alt2      <= alt2_st;
                sreg      <= RESET_REG;
                dreg      <= RESET_REG;
                bflag     <= 1'b0;
                alt1_st   <= 1'b0;
                alt2_st   <= 1'b0;
                src_set   <= 1'b0;
            end
        end else if (!dec_stall) begin
            dec_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fig_04b_block_074_prefix_decode.sv
// tb/tb_fig_04b_block_074_prefix_decode.sv - self-checking bench for fig_04b_block_074_prefix_decode
// Behavioural prefix model, per-cycle compare, directed literal checks and random traffic.
module tb_fig_04b_block_074_prefix_decode;

`ifdef FIG04B_BFLAG_MOVE_EN
    localparam bit FUSE = 1'b1;
`else
    localparam bit FUSE = 1'b0;
`endif

    logic       clk, reset, op_valid, op_ready, dec_stall, dec_valid;
    logic [7:0] op, dec_op;
    logic [3:0] xsel, ysel, zsel;
    logic       fromset, zwen, flag_upd, alt1, alt2;

    int n_vec  = 0;
    int n_fail = 0;

    fig_04b_block_074_prefix_decode dut (
        .clk(clk), .reset(reset), .op(op), .op_valid(op_valid), .op_ready(op_ready),
        .dec_stall(dec_stall), .dec_valid(dec_valid), .xsel(xsel), .ysel(ysel), .zsel(zsel),
        .fromset(fromset), .zwen(zwen), .flag_upd(flag_upd), .alt1(alt1), .alt2(alt2),
        .dec_op(dec_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: prefix state plus the expected decode word.
    logic [3:0] m_s, m_d;
    logic       m_b, m_a1, m_a2, m_src;
    logic       e_valid, e_from, e_zwen, e_flag, e_a1, e_a2;
    logic [3:0] e_x, e_y, e_z;
    logic [7:0] e_op;
    int         m_acc = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_s = 4'd0; m_d = 4'd0; m_b = 0; m_a1 = 0; m_a2 = 0; m_src = 0;
            e_valid = 0; e_x = 0; e_y = 0; e_z = 0; e_from = 0; e_zwen = 0;
            e_flag = 0; e_a1 = 0; e_a2 = 0; e_op = 8'h01;
        end else if (op_valid && (!e_valid || !dec_stall)) begin
            logic [3:0] h, n;
            logic       fused;
            h = op[7:4];
            n = op[3:0];
            fused = FUSE && m_b && (h == 4'h1 || h == 4'hB);
            m_acc++;
            if (h == 4'h2) begin
                m_s = n; m_d = n; m_b = 1; m_src = 1; e_valid = 0;
            end else if (h == 4'h1 && !fused) begin
                m_d = n; e_valid = 0;
            end else if (h == 4'hB && !fused) begin
                m_s = n; m_src = 1; e_valid = 0;
            end else if (op == 8'h3D || op == 8'h3E || op == 8'h3F) begin
                if (op != 8'h3E) m_a1 = 1;
                if (op != 8'h3D) m_a2 = 1;
                e_valid = 0;
            end else begin
                e_valid = 1; e_op = op; e_y = n; e_from = m_src; e_a1 = m_a1; e_a2 = m_a2;
                e_x = (fused && h == 4'hB) ? n : m_s;
                e_z = (fused && h == 4'h1) ? n : m_d;
                e_zwen = fused;
                e_flag = fused && h == 4'hB;
                m_s = 4'd0; m_d = 4'd0; m_b = 0; m_a1 = 0; m_a2 = 0; m_src = 0;
            end
        end else if (!dec_stall) begin
            e_valid = 0;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_valid", 8'(dec_valid), 8'h00);
            chk("rst_xyz", {xsel, zsel}, 8'h00);
            chk("rst_dec_op", dec_op, 8'h01);
        end else begin
            chk("op_ready", 8'(op_ready), 8'(!e_valid || !dec_stall));
            chk("dec_valid", 8'(dec_valid), 8'(e_valid));
            if (e_valid) begin
                chk("dec_op", dec_op, e_op);
                chk("xsel", 8'(xsel), 8'(e_x));
                chk("ysel", 8'(ysel), 8'(e_y));
                chk("zsel", 8'(zsel), 8'(e_z));
                chk("flags", {3'b0, fromset, zwen, flag_upd, alt1, alt2},
                    {3'b0, e_from, e_zwen, e_flag, e_a1, e_a2});
            end
        end
    end

    task automatic send(input logic [7:0] v);
        int c;
        bit ok;
        c = m_acc;
        ok = 0;
        op = v;
        op_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(posedge clk);
            #1;
            if (m_acc != c) begin
                ok = 1;
                break;
            end
        end
        op_valid = 1'b0;
        if (!ok) chk("accept_timeout", 8'h00, 8'h01);
    endtask

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 5))
            0: pick = {4'h1, 4'($urandom)};
            1: pick = {4'h2, 4'($urandom)};
            2: pick = {4'hB, 4'($urandom)};
            3: pick = 8'h3D + 8'($urandom_range(0, 2));
            default: pick = 8'($urandom);
        endcase
    endfunction

    initial begin
        reset = 1'b1; op_valid = 1'b0; op = 8'h00; dec_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        send(8'h05);
        chk("t1_valid", 8'(dec_valid), 8'h01);
        chk("t1_xz", {xsel, zsel}, 8'h00);
        chk("t1_ysel", 8'(ysel), 8'h05);
        chk("t1_from_zwen", {6'b0, fromset, zwen}, 8'h00);

        send(8'h13); send(8'hB4); send(8'h5A);
        chk("t2_xz", {xsel, zsel}, 8'h43);
        chk("t2_ysel", 8'(ysel), 8'h0A);
        chk("t2_fromset", 8'(fromset), 8'h01);
        send(8'h50);
        chk("t2_clear", {xsel, zsel}, 8'h00);

        send(8'h27); send(8'h12);
        if (FUSE) begin
            chk("move_xz", {xsel, zsel}, 8'h72);
            chk("move_zwen", {6'b0, zwen, flag_upd}, 8'h02);
            send(8'h27); send(8'hB9);
            chk("moves_xz", {xsel, zsel}, 8'h97);
            chk("moves_flag", {6'b0, zwen, flag_upd}, 8'h03);
        end else begin
            send(8'h50);
            chk("nofuse_xz", {xsel, zsel}, 8'h72);
            chk("nofuse_flags", {5'b0, fromset, zwen, flag_upd}, 8'h04);
        end

        send(8'h3D); send(8'h3E); send(8'h60);
        chk("alt_set", {6'b0, alt1, alt2}, 8'h03);
        send(8'h60);
        chk("alt_clr", {6'b0, alt1, alt2}, 8'h00);

        dec_stall = 1'b1;
        fork
            send(8'h61);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_ready", 8'(op_ready), 8'h00);
                    chk("stall_hold", dec_op, 8'h60);
                end
                @(posedge clk);
                #1 dec_stall = 1'b0;
            end
        join
        chk("stall_next", dec_op, 8'h61);

        send(8'hB6); send(8'h70);
        dec_stall = 1'b1;
        chk("held_x", 8'(xsel), 8'h06);
        #2 reset = 1'b1;
        #1;
        chk("async_valid", 8'(dec_valid), 8'h00);
        chk("async_xsel", 8'(xsel), 8'h00);
        chk("async_dec_op", dec_op, 8'h01);
        @(posedge clk);
        #1 reset = 1'b0; dec_stall = 1'b0;
        send(8'h71);
        chk("post_rst_x", 8'(xsel), 8'h00);
        chk("post_rst_from", 8'(fromset), 8'h00);

        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1;
            op_valid  = ($urandom_range(0, 3) != 0);
            dec_stall = ($urandom_range(0, 3) == 0);
            op        = pick();
        end
        op_valid = 1'b0;
        dec_stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
